controlador_minado: RTL and testbench

- Control stage directly upstream of the mining system; also consumes the miner's result.
- Receives a block header byte-serially over a valid/ready handshake and assembles the 96-bit data_in word and the 8-bit target.
- Releases the miner from reset, times the search and captures nonce_out when finished rises.
- Holds the result for a downstream consumer until acknowledged, with a cycle-count timeout.

---
 rtl/controlador_minado.sv | 110 +++++++++++
 tb/tb_controlador_minado.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_minado.sv
// Mining front-end controller: assembles a byte-serial header and target, releases
// the miner, times the search and holds the nonce/timeout result until acknowledged.
module controlador_minado #(
  parameter int                 BYTE_W  = 8,
  parameter int                 N_BYTES = 12,
  parameter int                 CNT_W   = 16,
  parameter logic [CNT_W-1:0]   TIMEOUT = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BYTE_W-1:0]           byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [BYTE_W*N_BYTES-1:0]   data_in,
  output logic [7:0]                  target,
  output logic                        miner_reset,
  input  logic                        finished,
  input  logic [31:0]                 nonce_out,
  output logic [31:0]                 nonce_result,
  output logic [CNT_W-1:0]            cycles,
  output logic                        timed_out,
  output logic                        result_valid,
  input  logic                        result_ack
);
  localparam int               IDX_W = $clog2(N_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_BYTES);
  localparam logic [CNT_W-1:0] TO_M1 = TIMEOUT - CNT_W'(1);

  typedef enum logic [1:0] {LOAD, MINE, DONE} state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_cnt;
  logic [BYTE_W*N_BYTES-1:0]   r_data;
  logic [7:0]                  r_target;
  logic                        r_miner_rst;
  logic [31:0]                 r_nonce;
  logic [CNT_W-1:0]            r_cycles;
  logic                        r_timed_out;
  logic                        r_res_vld;

  // Gated by reset so the block never advertises readiness while held.
  assign byte_ready   = (r_state == LOAD) && reset;
  assign data_in      = r_data;
  assign target       = r_target;
  assign miner_reset  = r_miner_rst;
  assign nonce_result = r_nonce;
  assign cycles       = r_cycles;
  assign timed_out    = r_timed_out;
  assign result_valid = r_res_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_target    <= '0;
      r_miner_rst <= 1'b0;
      r_nonce     <= '0;
      r_cycles    <= '0;
      r_timed_out <= 1'b0;
      r_res_vld   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (byte_valid) begin
            if (r_idx == LAST) begin
              r_target    <= byte_in;
              r_cnt       <= '0;
              r_miner_rst <= 1'b1;
              r_state     <= MINE;
            end else begin
              // Header arrives MSB-first: byte 0 lands in the top byte lane.
              r_data[(N_BYTES-1-int'(r_idx))*BYTE_W +: BYTE_W] <= byte_in;
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        MINE: begin
          if (finished) begin
            r_nonce     <= nonce_out;
            r_cycles    <= r_cnt;
            r_timed_out <= 1'b0;
            r_res_vld   <= 1'b1;
            r_miner_rst <= 1'b0;
            r_state     <= DONE;
          end else if (r_cnt == TO_M1) begin
            r_nonce     <= '0;
            r_cycles    <= TIMEOUT;
            r_timed_out <= 1'b1;
            r_res_vld   <= 1'b1;
            r_miner_rst <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (result_ack && r_res_vld) begin
            r_res_vld <= 1'b0;
            r_idx     <= '0;
            r_state   <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_controlador_minado.sv
// Directed + randomized bench for controlador_minado against a transaction-level model.
module tb_controlador_minado;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [95:0] data_in;
  logic [7:0]  target;
  logic        miner_reset;
  logic        finished;
  logic [31:0] nonce_out;
  logic [31:0] nonce_result;
  logic [15:0] cycles;
  logic        timed_out;
  logic        result_valid;
  logic        result_ack;

  controlador_minado #(.BYTE_W(8), .N_BYTES(12), .CNT_W(16), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .data_in(data_in), .target(target),
    .miner_reset(miner_reset), .finished(finished), .nonce_out(nonce_out),
    .nonce_result(nonce_result), .cycles(cycles), .timed_out(timed_out),
    .result_valid(result_valid), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [7:0]  hdr [13];
  logic [95:0] m_data;
  logic [7:0]  m_target;
  logic [31:0] m_nonce;
  logic [15:0] m_cycles;
  logic        m_to;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [95:0] pack_hdr();
    logic [95:0] v = '0;
    for (int i = 0; i < 12; i++) v = {v[87:0], hdr[i]};
    return v;
  endfunction

  task automatic rand_hdr();
    for (int i = 0; i < 13; i++) hdr[i] = 8'($urandom);
  endtask

  // Feed the first n header bytes, with up to bub idle cycles before each.
  task automatic load_bytes(input int n, input int bub);
    for (int i = 0; i < n; i++) begin
      int nb = (bub == 0) ? 0 : int'($urandom_range(0, bub));
      repeat (nb) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        step();
      end
      chk("ready_in_load", 128'(byte_ready), 128'(1));
      chk("miner_held_in_load", 128'(miner_reset), 128'(0));
      byte_valid = 1'b1;
      byte_in    = hdr[i];
      step();
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_loaded();
    chk("data_in", 128'(data_in), 128'(pack_hdr()));
    chk("target", 128'(target), 128'(hdr[12]));
    chk("miner_released", 128'(miner_reset), 128'(1));
    chk("ready_low_mine", 128'(byte_ready), 128'(0));
  endtask

  // Model: finished raised after k counted MINE cycles; timeout after TO cycles.
  task automatic mine(input int k, input logic [31:0] n);
    int nsteps = (k < TO) ? k : TO;
    for (int c = 0; c < nsteps; c++) begin
      chk("no_result_yet", 128'(result_valid), 128'(0));
      byte_valid = $urandom_range(0, 1);
      byte_in    = 8'($urandom);
      step();
    end
    byte_valid = 1'b0;
    if (k < TO) begin
      finished = 1'b1; nonce_out = n;
      step();
      finished = 1'b0; nonce_out = 32'($urandom);
      m_nonce = n; m_cycles = 16'(k); m_to = 1'b0;
    end else begin
      m_nonce = '0; m_cycles = 16'(TO); m_to = 1'b1;
    end
    chk("result_valid", 128'(result_valid), 128'(1));
    chk("nonce_result", 128'(nonce_result), 128'(m_nonce));
    chk("cycles", 128'(cycles), 128'(m_cycles));
    chk("timed_out", 128'(timed_out), 128'(m_to));
    chk("miner_held_done", 128'(miner_reset), 128'(0));
  endtask

  task automatic hold_and_ack(input int hold);
    for (int c = 0; c < hold; c++) begin
      byte_valid = 1'b1; byte_in = 8'($urandom);
      step();
      chk("hold_valid", 128'(result_valid), 128'(1));
      chk("hold_nonce", 128'(nonce_result), 128'(m_nonce));
      chk("hold_data", 128'(data_in), 128'(pack_hdr()));
      chk("hold_ready", 128'(byte_ready), 128'(0));
    end
    byte_valid = 1'b0;
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    chk("ack_valid_low", 128'(result_valid), 128'(0));
    chk("ack_ready", 128'(byte_ready), 128'(1));
    chk("ack_keep_cycles", 128'(cycles), 128'(m_cycles));
    chk("ack_keep_to", 128'(timed_out), 128'(m_to));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 128'(byte_ready), 128'(0));
    chk({tag, "_data"}, 128'(data_in), 128'(0));
    chk({tag, "_target"}, 128'(target), 128'(0));
    chk({tag, "_mrst"}, 128'(miner_reset), 128'(0));
    chk({tag, "_res"}, 128'({nonce_result, cycles, timed_out, result_valid}), 128'(0));
  endtask

  initial begin
    int c0;
    reset = 1'b0; byte_in = '0; byte_valid = 1'b0; finished = 1'b0;
    nonce_out = '0; result_ack = 1'b0;
    #3;
    check_reset_vals("por");
    #14 reset = 1'b1;
    step();

    // Directed header 01..0C, target 10, back-to-back.
    for (int i = 0; i < 12; i++) hdr[i] = 8'(i + 1);
    hdr[12] = 8'h10;
    c0 = cyc;
    load_bytes(13, 0);
    chk("load_cycles", 128'(cyc - c0), 128'(13));
    check_loaded();
    mine(5, 32'h0000_1234);
    hold_and_ack(10);

    // Timeout, then finished coincident with the timeout edge.
    rand_hdr(); load_bytes(13, 0); check_loaded();
    mine(TO, 32'hDEAD_BEEF);
    hold_and_ack(2);
    rand_hdr(); load_bytes(13, 2); check_loaded();
    mine(TO - 1, 32'hCAFE_F00D);
    hold_and_ack(1);
    rand_hdr(); load_bytes(13, 0); check_loaded();
    mine(0, 32'h0BAD_0001);
    hold_and_ack(0);

    // Randomized headers with bubbles and random finish points.
    for (int t = 0; t < 8; t++) begin
      rand_hdr();
      load_bytes(13, 3);
      check_loaded();
      mine(int'($urandom_range(0, TO + 2)), 32'($urandom));
      hold_and_ack(int'($urandom_range(0, 4)));
    end

    // Asynchronous reset mid-MINE.
    rand_hdr(); load_bytes(13, 0); check_loaded();
    step(); step();
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mine");
    #2 reset = 1'b1;
    step();

    // Reset after five bytes; partial header must be discarded.
    rand_hdr(); load_bytes(5, 1);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_load");
    #2 reset = 1'b1;
    step();
    rand_hdr();
    load_bytes(12, 1);
    chk("no_release_12", 128'(miner_reset), 128'(0));
    load_bytes(0, 0);
    byte_valid = 1'b1; byte_in = hdr[12];
    step();
    byte_valid = 1'b0;
    check_loaded();
    mine(3, 32'h5555_AAAA);
    hold_and_ack(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
